// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding and default bus geometry.
// Masters, slaves and wrappers import this package to decode arbiter_state.
package bus_pkg;

    localparam int NUM_MASTERS     = 2;
    localparam int SLAVE_ID_W_DEF  = 2;
    localparam int NUM_SLAVES_DEF  = 3;
    localparam int STATE_W         = 3;

    // Arbiter FSM encoding; values 5..7 are never produced and fall back to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DECODE = 3'd2,
        XFER   = 3'd3,
        NACK   = 3'd4
    } arb_state_e;

    // True while some master owns the bus (grant held).
    function automatic logic bus_owned(input logic [STATE_W-1:0] st);
        return (st == ADDR) || (st == DECODE) || (st == XFER) || (st == NACK);
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select for the two-master arbiter.
// Produces a one-hot winner from the current requests and the last grant.
module arb_rr_pick
    import bus_pkg::*;
#(
    parameter int RR_MODE = 1
) (
    input  logic [NUM_MASTERS-1:0] m_req,
    input  logic [NUM_MASTERS-1:0] last_gnt,
    output logic [NUM_MASTERS-1:0] winner
);

    // A lone requester always wins; on contention either alternate or favour master 0.
    always_comb begin
        winner = m_req;
        if (m_req == 2'b11) begin
            if ((RR_MODE != 0) && last_gnt[0]) begin
                winner = 2'b10;
            end else begin
                winner = 2'b01;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// Two-master bus arbiter and slave-select controller.
// Grants the shared serial bus, captures the slave ID sent MSB first by the
// granted master, decodes it to a one-hot select, holds the connection until
// tx_done, master release or watchdog expiry, then releases the bus with at
// least one idle turnaround cycle. All outputs come straight from flops.
module bus_arbiter_ctrl
    import bus_pkg::*;
#(
    parameter int SLAVE_ID_W = SLAVE_ID_W_DEF,
    parameter int NUM_SLAVES = NUM_SLAVES_DEF,
    parameter int TIMEOUT    = 255,
    parameter int RR_MODE    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            m_req,
    input  logic                  bus_serial_in,
    input  logic [NUM_SLAVES-1:0] s_ready,
    input  logic                  tx_done,
    output logic [1:0]            m_gnt,
    output logic [NUM_SLAVES-1:0] s_sel,
    output logic                  m_ack,
    output logic                  m_nack,
    output logic                  timeout,
    output logic [2:0]            arbiter_state
);

    // Bit counter spans 0..SLAVE_ID_W-1, watchdog spans 0..TIMEOUT-1.
    localparam int CNT_W = (SLAVE_ID_W > 1) ? $clog2(SLAVE_ID_W + 1) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLAVE_ID_W - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    arb_state_e                state_q,    state_d;
    logic [1:0]                gnt_q,      gnt_d;
    logic [1:0]                last_gnt_q, last_gnt_d;
    logic [NUM_SLAVES-1:0]     sel_q,      sel_d;
    logic                      ack_q,      ack_d;
    logic                      nack_q,     nack_d;
    logic                      to_q,       to_d;
    logic [SLAVE_ID_W-1:0]     id_q,       id_d;
    logic [CNT_W-1:0]          bit_cnt_q,  bit_cnt_d;
    logic [WD_W-1:0]           wdog_q,     wdog_d;

    logic [1:0]                winner;
    logic [NUM_SLAVES-1:0]     sel_dec;
    logic [SLAVE_ID_W:0]       id_shift;
    logic                      req_held;
    logic                      slave_ok;
    logic                      wdog_hit;
    logic                      release_xfer;

    arb_rr_pick #(
        .RR_MODE (RR_MODE)
    ) u_pick (
        .m_req    (m_req),
        .last_gnt (last_gnt_q),
        .winner   (winner)
    );

    // The granted master keeps ownership only while it keeps its request up.
    assign req_held     = |(m_req & gnt_q);
    assign id_shift     = {id_q, bus_serial_in};
    assign wdog_hit     = (wdog_q == WD_LAST);
    assign release_xfer = tx_done || !req_held || wdog_hit;

    // Decode the captured ID into a one-hot select; out-of-range IDs decode to zero.
    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(id_q) == i) begin
                sel_dec[i] = 1'b1;
            end
        end
    end

    // A connection is possible only if the ID names an existing slave that is ready.
    assign slave_ok = |(sel_dec & s_ready);

    // State, grant, select, pulses, ID shifter and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= 2'b10;
            sel_q      <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            to_q       <= 1'b0;
            id_q       <= '0;
            bit_cnt_q  <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            sel_q      <= sel_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            to_q       <= to_d;
            id_q       <= id_d;
            bit_cnt_q  <= bit_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        sel_d      = sel_q;
        ack_d      = 1'b0;
        nack_d     = 1'b0;
        to_d       = 1'b0;
        id_d       = id_q;
        bit_cnt_d  = bit_cnt_q;
        wdog_d     = wdog_q;

        case (state_q)
            IDLE: begin
                if (|m_req) begin
                    gnt_d     = winner;
                    id_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = ADDR;
                end
            end

            ADDR: begin
                // An abandoned address phase does not count as a grant for fairness.
                if (!req_held) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    id_d      = id_shift[SLAVE_ID_W-1:0];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = DECODE;
                    end
                end
            end

            DECODE: begin
                if (slave_ok) begin
                    sel_d   = sel_dec;
                    ack_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = XFER;
                end else begin
                    nack_d  = 1'b1;
                    state_d = NACK;
                end
            end

            XFER: begin
                // tx_done outranks the watchdog, so a coincident finish is not a timeout.
                if (release_xfer) begin
                    gnt_d      = '0;
                    sel_d      = '0;
                    last_gnt_d = gnt_q;
                    to_d       = wdog_hit && !tx_done;
                    state_d    = IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end

            NACK: begin
                // The rejected master is recorded so it yields on the next contention.
                gnt_d      = '0;
                last_gnt_d = gnt_q;
                state_d    = IDLE;
            end

            default: begin
                gnt_d   = '0;
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign m_gnt         = gnt_q;
    assign s_sel         = sel_q;
    assign m_ack         = ack_q;
    assign m_nack        = nack_q;
    assign timeout       = to_q;
    assign arbiter_state = state_q;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Directed bench for bus_arbiter_ctrl. Two instances share the stimulus:
// dut_a uses round-robin with a 4-cycle watchdog, dut_b fixed priority
// with the default watchdog.
module tb_bus_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] m_req;
    logic       bus_serial_in;
    logic [2:0] s_ready;
    logic       tx_done;

    logic [1:0] gnt_a, gnt_b;
    logic [2:0] sel_a, sel_b;
    logic       ack_a, ack_b, nack_a, nack_b, to_a, to_b;
    logic [2:0] st_a, st_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_arbiter_ctrl #(
        .SLAVE_ID_W (2),
        .NUM_SLAVES (3),
        .TIMEOUT    (4),
        .RR_MODE    (1)
    ) dut_a (
        .clk           (clk),
        .reset         (reset),
        .m_req         (m_req),
        .bus_serial_in (bus_serial_in),
        .s_ready       (s_ready),
        .tx_done       (tx_done),
        .m_gnt         (gnt_a),
        .s_sel         (sel_a),
        .m_ack         (ack_a),
        .m_nack        (nack_a),
        .timeout       (to_a),
        .arbiter_state (st_a)
    );

    bus_arbiter_ctrl #(
        .SLAVE_ID_W (2),
        .NUM_SLAVES (3),
        .TIMEOUT    (255),
        .RR_MODE    (0)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .m_req         (m_req),
        .bus_serial_in (bus_serial_in),
        .s_ready       (s_ready),
        .tx_done       (tx_done),
        .m_gnt         (gnt_b),
        .s_sel         (sel_b),
        .m_ack         (ack_b),
        .m_nack        (nack_b),
        .timeout       (to_b),
        .arbiter_state (st_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m_req         = 2'b00;
        tx_done       = 1'b0;
        bus_serial_in = 1'b0;
        s_ready       = 3'b111;
        reset         = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        m_req = 2'b00; tx_done = 1'b0; bus_serial_in = 1'b0; s_ready = 3'b111;
        reset = 1'b0;
        #3;
        check("rst_gnt",  gnt_a,  0);
        check("rst_sel",  sel_a,  0);
        check("rst_st",   st_a,   0);
        check("rst_ack",  ack_a,  0);
        check("rst_nack", nack_a, 0);
        check("rst_to",   to_a,   0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single request, ID 2 (bits 1,0), tx_done at edge 10 (fixed-priority instance)
        do_reset();
        m_req = 2'b01; bus_serial_in = 1'b1;
        tick();
        check("t1_gnt_e1", gnt_b, 2'b01);
        check("t1_st_e1",  st_b,  1);
        tick();
        bus_serial_in = 1'b0;
        check("t1_st_e2",  st_b,  1);
        tick();
        check("t1_st_e3",  st_b,  2);
        check("t1_sel_e3", sel_b, 0);
        tick();
        check("t1_sel_e4", sel_b, 3'b100);
        check("t1_ack_e4", ack_b, 1);
        check("t1_st_e4",  st_b,  3);
        tick();
        check("t1_ack_e5", ack_b, 0);
        check("t1_sel_e5", sel_b, 3'b100);
        repeat (4) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0; m_req = 2'b00;
        check("t1_gnt_rel", gnt_b, 0);
        check("t1_sel_rel", sel_b, 0);
        check("t1_st_rel",  st_b,  0);

        // Contention: round-robin alternates, fixed priority sticks to master 0
        do_reset();
        m_req = 2'b11; bus_serial_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_gnt_rr", gnt_a, (k == 1) ? 2'b10 : 2'b01);
            check("t2_gnt_fp", gnt_b, 2'b01);
            repeat (3) tick();
            check("t2_ack", ack_a, 1);
            check("t2_sel", sel_a, 3'b001);
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check("t2_turn_gnt", gnt_a, 0);
            check("t2_turn_st",  st_a,  0);
            check("t2_turn_fp",  gnt_b, 0);
        end
        m_req = 2'b00;

        // Invalid ID 3
        do_reset();
        m_req = 2'b01; bus_serial_in = 1'b1;
        repeat (3) tick();
        check("t3_st_dec", st_b, 2);
        tick();
        check("t3_nack",     nack_b, 1);
        check("t3_sel",      sel_b,  0);
        check("t3_st_nack",  st_b,   4);
        check("t3_gnt_hold", gnt_b,  2'b01);
        m_req = 2'b00;
        tick();
        check("t3_gnt_rel", gnt_b,  0);
        check("t3_nack_lo", nack_b, 0);
        check("t3_st_rel",  st_b,   0);

        // ID 1 with slave 1 not ready; rejected master 0 then yields under round-robin
        do_reset();
        s_ready = 3'b101; m_req = 2'b01; bus_serial_in = 1'b0;
        tick();
        tick();
        bus_serial_in = 1'b1;
        tick();
        tick();
        check("t3b_nack", nack_a, 1);
        check("t3b_sel",  sel_a,  0);
        check("t3b_ack",  ack_a,  0);
        tick();
        check("t3b_gnt_rel", gnt_a, 0);
        check("t3b_st_rel",  st_a,  0);
        m_req = 2'b11;
        tick();
        check("t3b_rr_next", gnt_a, 2'b10);
        check("t3b_fp_next", gnt_b, 2'b01);

        // Watchdog expiry after 4 XFER cycles
        do_reset();
        m_req = 2'b01; bus_serial_in = 1'b0;
        repeat (4) tick();
        check("t4_st_xfer", st_a, 3);
        repeat (3) tick();
        check("t4_st_c4", st_a, 3);
        check("t4_to_c4", to_a, 0);
        tick();
        check("t4_to",     to_a,  1);
        check("t4_gnt",    gnt_a, 0);
        check("t4_sel",    sel_a, 0);
        check("t4_st_rel", st_a,  0);
        m_req = 2'b00;
        tick();
        check("t4_to_lo", to_a, 0);

        // tx_done in the 4th XFER cycle wins over the watchdog
        do_reset();
        m_req = 2'b01; bus_serial_in = 1'b0;
        repeat (7) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0; m_req = 2'b00;
        check("t4b_to",  to_a,  0);
        check("t4b_gnt", gnt_a, 0);
        check("t4b_st",  st_a,  0);

        // Abort after one ID bit; last grant must stay untouched
        do_reset();
        m_req = 2'b01; bus_serial_in = 1'b1;
        tick();
        check("t5_gnt", gnt_a, 2'b01);
        tick();
        m_req = 2'b00;
        tick();
        check("t5_gnt_rel", gnt_a,  0);
        check("t5_st",      st_a,   0);
        check("t5_ack",     ack_a,  0);
        check("t5_nack",    nack_a, 0);
        m_req = 2'b11;
        tick();
        check("t5_rr_keep", gnt_a, 2'b01);

        // Asynchronous reset in the middle of a transfer to slave 1
        do_reset();
        m_req = 2'b10; bus_serial_in = 1'b0;
        tick();
        tick();
        bus_serial_in = 1'b1;
        tick();
        tick();
        check("t6_sel", sel_a, 3'b010);
        check("t6_gnt", gnt_a, 2'b10);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_gnt", gnt_a, 0);
        check("t6_rst_sel", sel_a, 0);
        check("t6_rst_st",  st_a,  0);
        check("t6_rst_ack", ack_a, 0);
        check("t6_rst_to",  to_a,  0);
        @(posedge clk); #1;
        reset = 1'b1;
        m_req = 2'b11;
        tick();
        check("t6_gnt_after", gnt_a, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
